// File: rtl/bram_burst_reader_if.sv
// Bundle of the command, RAM read-port and output-stream signals of bram_burst_reader.
// slave = the reader's view of the bundle; master = the environment driving commands and the RAM.
interface bram_burst_reader_if #(
  parameter int ADDR_W = 12
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [15:0]       mem_data;
  logic              mem_valid;

  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              out_last;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, mem_data, mem_valid, out_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, mem_data, mem_valid, out_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst read sequencer: turns (addr, len) commands into one-per-cycle block RAM reads and streams the words out.
// Define BURST_READER_ERR_CHK_EN to enable the sticky protocol-error flag o_err.
module bram_burst_reader #(
  parameter int NUM_BLOCKS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bram_burst_reader_if.slave bus,
  output logic               o_busy,
  output logic               o_err
);
  localparam int ADDR_W = 8 + $clog2(NUM_BLOCKS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   w_remaining_next;

  logic              r_rd_en;
  logic              r_rd_last;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_issue_addr;

  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_guard;

  logic [15:0]       r_fifo_data [FIFO_DEPTH];
  logic              r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_mem_valid;
  logic              w_cmd_ready;
  logic              w_credit;
  logic [CNT_W:0]    w_outstanding;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_pop       = !w_empty && bus.out_ready;
  // r_guard masks the first cycle after reset so a RAM response to a pre-reset read is never captured
  assign w_mem_valid = bus.mem_valid && !r_guard;
  assign w_cmd_ready = (r_state == S_IDLE) && w_empty && !r_guard;

  // Every word that may still land in the FIFO: stored, returning this cycle, or on the RAM bus now
  assign w_outstanding = {1'b0, r_count}
                       + {{CNT_W{1'b0}}, r_inflight}
                       + {{CNT_W{1'b0}}, r_rd_en}
                       - {{CNT_W{1'b0}}, w_pop};
  assign w_credit = (w_outstanding < DEPTH_X);

`ifdef BURST_READER_ERR_CHK_EN
  logic r_err;

  assign w_push = w_mem_valid && r_inflight && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_mem_valid && (!r_inflight || (w_full && !w_pop))) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_push = w_mem_valid && (!w_full || w_pop);
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_guard     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_guard     <= 1'b0;
    end
  end

  // The first read of a burst issues on the accepting edge, so data reaches the output two cycles later
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_issue          = 1'b0;
    w_issue_last     = 1'b0;
    w_issue_addr     = r_addr;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready && (bus.cmd_len != '0)) begin
          w_issue          = 1'b1;
          w_issue_addr     = bus.cmd_addr;
          w_issue_last     = (bus.cmd_len == LEN_ONE);
          w_addr_next      = bus.cmd_addr + 1'b1;
          w_remaining_next = bus.cmd_len - 1'b1;
          w_state_next     = (bus.cmd_len == LEN_ONE) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_credit) begin
          w_issue          = 1'b1;
          w_issue_addr     = r_addr;
          w_issue_last     = (r_remaining == LEN_ONE);
          w_addr_next      = r_addr + 1'b1;
          w_remaining_next = r_remaining - 1'b1;
          if (r_remaining == LEN_ONE) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!r_rd_en && !r_inflight && w_empty) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The last-word tag follows each read through the RAM latency so it pairs with its returning data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_en         <= 1'b0;
      r_rd_last       <= 1'b0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_rd_en         <= w_issue;
      r_rd_last       <= w_issue && w_issue_last;
      r_inflight      <= r_rd_en;
      r_inflight_last <= r_rd_en && r_rd_last;
      if (w_issue) begin
        r_rd_addr <= w_issue_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.mem_data;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.mem_rd_en   = r_rd_en;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = w_empty ? 16'h0000 : r_fifo_data[r_rd_ptr];
  assign bus.out_last    = w_empty ? 1'b0 : r_fifo_last[r_rd_ptr];
  assign o_busy          = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_bram_burst_reader.sv
// Testbench for bram_burst_reader: behavioural RAM, queue-based scoreboard and randomized bursts.
// Expected read addresses and output words come from the command (addr, len) and the RAM contents alone.
module tb_bram_burst_reader;
  localparam int NUM_BLOCKS = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 12;
  localparam int MEM_WORDS  = 4096;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  bram_burst_reader_if #(.ADDR_W(ADDR_W)) bus ();

  bram_burst_reader #(
    .NUM_BLOCKS(NUM_BLOCKS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .o_busy (busy),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  logic [15:0]       mem [MEM_WORDS];
  logic              injectValid = 1'b0;
  int                readyMode = 1;
  word_t             expWords [$];
  logic [ADDR_W-1:0] expAddrs [$];
  int                errors = 0;
  int                checks = 0;
  int                readCount = 0;
  logic              holdPrev = 1'b0;
  logic [15:0]       holdData = '0;
  logic              holdLast = 1'b0;
  word_t             monWord;
  logic [ADDR_W-1:0] monAddr;

  // Block RAM with one cycle of read latency; injectValid fakes a spurious response
  always @(posedge clk) begin
    bus.mem_valid <= bus.mem_rd_en || injectValid;
    bus.mem_data  <= mem[bus.mem_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      holdPrev = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        readCount++;
        if (expAddrs.size() == 0) begin
          failNow("unexpected_read");
        end else begin
          monAddr = expAddrs.pop_front();
          checkOutput("read_addr", 32'(bus.mem_rd_addr), 32'(monAddr));
        end
      end
      if (holdPrev) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_data", 32'(bus.out_data), 32'(holdData));
        checkOutput("hold_last", 32'(bus.out_last), 32'(holdLast));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expWords.size() == 0) begin
          failNow("unexpected_out");
        end else begin
          monWord = expWords.pop_front();
          checkOutput("out_data", 32'(bus.out_data), 32'(monWord.data));
          checkOutput("out_last", 32'(bus.out_last), 32'(monWord.last));
        end
      end
      holdPrev = bus.out_valid && !bus.out_ready;
      holdData = bus.out_data;
      holdLast = bus.out_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] len);
    int                n = 0;
    logic [ADDR_W-1:0] a;
    word_t             w;
    while (!bus.cmd_ready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      failNow("cmd_ready_timeout");
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + ADDR_W'(i);
      expAddrs.push_back(a);
      w.data = mem[a];
      w.last = (i == int'(len) - 1);
      expWords.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || expWords.size() != 0 || bus.mem_valid) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) failNow({name, "_timeout"});
    checkOutput({name, "_leftover"}, 32'(expWords.size()), 32'd0);
    checkOutput({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    checkOutput({name, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    checkOutput({name, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    checkOutput({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_out_data"}, 32'(bus.out_data), 32'd0);
    checkOutput({name, "_out_last"}, 32'(bus.out_last), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  base;
    int  n;
    logic sawValid;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'(i);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] basic burst");
    applyStimulus(12'h010, 13'd4);
    for (int c = 0; c < 5; c++) begin
      checkOutput("basic_rd_en", 32'(bus.mem_rd_en), 32'(c < 4));
      checkOutput("basic_out_valid", 32'(bus.out_valid), 32'(c >= 2));
      @(posedge clk);
      #1;
    end
    waitIdle("basic");

    $display("[TB] backpressure");
    readyMode = 0;
    @(posedge clk);
    #1;
    base = readCount;
    applyStimulus(12'h000, 13'd10);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_reads", 32'(readCount - base), 32'(FIFO_DEPTH));
    checkOutput("bp_rd_en", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_data", 32'(bus.out_data), 32'h0000);
    readyMode = 1;
    waitIdle("backpressure");

    $display("[TB] wrap");
    applyStimulus(12'hFFE, 13'd4);
    waitIdle("wrap");

    $display("[TB] zero length");
    base = readCount;
    sawValid = 1'b0;
    applyStimulus(12'h055, 13'd0);
    repeat (6) begin
      sawValid = sawValid | bus.out_valid;
      @(posedge clk);
      #1;
    end
    checkOutput("zero_reads", 32'(readCount - base), 32'd0);
    checkOutput("zero_out_valid", 32'(sawValid), 32'd0);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] reset mid-burst");
    base = readCount;
    applyStimulus(12'h040, 13'd8);
    n = 0;
    while (readCount < base + 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) failNow("midreset_timeout");
    #1;
    rst_n = 1'b0;
    expWords.delete();
    expAddrs.delete();
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(12'h020, 13'd2);
    waitIdle("after_reset");

    $display("[TB] full-length burst");
    applyStimulus(12'h123, 13'd4096);
    waitIdle("full_len");

    $display("[TB] random bursts");
    readyMode = 2;
    for (int k = 0; k < 16; k++) begin
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W:0]   rl;
      ra = ADDR_W'($urandom_range(0, MEM_WORDS - 1));
      rl = (k % 5 == 4) ? '0 : (ADDR_W+1)'($urandom_range(1, 24));
      applyStimulus(ra, rl);
    end
    waitIdle("random");
    readyMode = 1;

`ifdef BURST_READER_ERR_CHK_EN
    $display("[TB] error check");
    checkOutput("err_clear", 32'(err), 32'd0);
    injectValid = 1'b1;
    @(posedge clk);
    #1;
    injectValid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("err_set", 32'(err), 32'd1);
    checkOutput("err_no_word", 32'(bus.out_valid), 32'd0);
    applyStimulus(12'h100, 13'd3);
    waitIdle("err_burst");
    checkOutput("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("err_reset", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    checkOutput("err_tied", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
